// File: rtl/data_cache_sa_if.sv
// Processor-side request/response and memory-side fill/write-through signals of data_cache_sa.
// The cache is the slave; the processor and the memory system form the master side.
interface data_cache_sa_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshakes: a request transfers on a rising edge where its valid and
  // ready are both high; valid and its payload stay stable until then.
  // cpu_done and mem_rvalid are single-cycle pulses with no back-pressure.
  logic              cpu_req_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_done, cpu_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_done, cpu_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/data_cache_sa.sv
// Set-associative, write-through, one-word-per-line data cache with round-robin
// replacement, single-cycle flush and saturating load hit/miss counters.
module data_cache_sa #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 8,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  data_cache_sa_if.slave   bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [2:0]       dbgState
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  typedef enum logic [2:0] {IDLE, COMPARE, FILL_REQ, FILL_WAIT, WR_REQ} state_t;

  state_t state, nextState;

  logic              reqWe;
  logic [ADDR_W-3:0] reqWord;
  logic [DATA_W-1:0] reqWdata;
  logic [DATA_W-1:0] rdataReg;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  logic [SETS-1:0]   validBits [WAYS];
  logic [TAG_W-1:0]  tagMem    [WAYS][SETS];
  logic [DATA_W-1:0] dataMem   [WAYS][SETS];
  logic [WAY_W-1:0]  victimPtr [SETS];

  logic              hit;
  logic [WAY_W-1:0]  hitWay;
  logic [DATA_W-1:0] hitData;
  logic              allValid;
  logic [WAY_W-1:0]  victim;
  logic              cpuDone;
  logic [DATA_W-1:0] cpuRdata;
  logic              memReqValid;
  logic              fillDone;
  logic              unusedAddrBits;

  assign idx = reqWord[IDX_W-1:0];
  assign tag = reqWord[ADDR_W-3 -: TAG_W];
  assign unusedAddrBits = ^bus.cpu_addr[1:0];
  assign fillDone = (state == FILL_WAIT) && bus.mem_rvalid;

  always_comb begin
    hit     = 1'b0;
    hitWay  = '0;
    hitData = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (validBits[w][idx] && (tagMem[w][idx] == tag)) begin
        hit     = 1'b1;
        hitWay  = WAY_W'(w);
        hitData = dataMem[w][idx];
      end
    end
  end

  // Scanning downward leaves the lowest-index invalid way selected.
  always_comb begin
    allValid = 1'b1;
    victim   = victimPtr[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!validBits[w][idx]) begin
        allValid = 1'b0;
        victim   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    nextState   = state;
    cpuDone     = 1'b0;
    cpuRdata    = rdataReg;
    memReqValid = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && bus.cpu_req_valid) nextState = COMPARE;
      end
      COMPARE: begin
        if (reqWe) begin
          nextState = WR_REQ;
        end else if (hit) begin
          cpuDone   = 1'b1;
          cpuRdata  = hitData;
          nextState = IDLE;
        end else begin
          nextState = FILL_REQ;
        end
      end
      FILL_REQ: begin
        memReqValid = 1'b1;
        if (bus.mem_req_ready) nextState = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (bus.mem_rvalid) begin
          cpuDone   = 1'b1;
          cpuRdata  = bus.mem_rdata;
          nextState = IDLE;
        end
      end
      WR_REQ: begin
        memReqValid = 1'b1;
        if (bus.mem_req_ready) begin
          cpuDone   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.cpu_ready     = (state == IDLE) && !flush;
  assign bus.cpu_done      = cpuDone;
  assign bus.cpu_rdata     = cpuRdata;
  assign bus.mem_req_valid = memReqValid;
  assign bus.mem_we        = (state == WR_REQ);
  assign bus.mem_addr      = {reqWord, 2'b00};
  assign bus.mem_wdata     = reqWdata;
  assign dbgState          = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      reqWe      <= 1'b0;
      reqWord    <= '0;
      reqWdata   <= '0;
      rdataReg   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int w = 0; w < WAYS; w++) validBits[w] <= '0;
      for (int s = 0; s < SETS; s++) victimPtr[s] <= '0;
    end else begin
      state    <= nextState;
      rdataReg <= cpuRdata;
      if (state == IDLE && !flush && bus.cpu_req_valid) begin
        reqWe    <= bus.cpu_we;
        reqWord  <= bus.cpu_addr[ADDR_W-1:2];
        reqWdata <= bus.cpu_wdata;
      end
      if (state == COMPARE && !reqWe) begin
        if (hit) begin
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
        end else if (miss_count != '1) begin
          miss_count <= miss_count + 1'b1;
        end
      end
      if (state == IDLE && flush) begin
        for (int w = 0; w < WAYS; w++) validBits[w] <= '0;
        for (int s = 0; s < SETS; s++) victimPtr[s] <= '0;
      end else if (fillDone) begin
        validBits[victim][idx] <= 1'b1;
        // The pointer only moves when a live line was evicted.
        if (allValid && WAYS > 1) victimPtr[idx] <= victimPtr[idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == COMPARE && reqWe && hit) dataMem[hitWay][idx] <= reqWdata;
    if (fillDone) begin
      tagMem[victim][idx]  <= tag;
      dataMem[victim][idx] <= bus.mem_rdata;
    end
  end
endmodule
